alu_output_queue: RTL

Parametrised successor to the combinational ALU output stage. It accepts one prioritised ALU result per cycle, builds the 2-bit response code, and routes the result to one of NUM_PORTS per-port FIFOs. Each requester port drains its FIFO through a valid/acknowledge handshake. The block sits between the ALU priority logic and the requester ports, and lets a port stall without losing results destined for it.

---
 rtl/alu_output_queue_if.sv | 44 ++++
 rtl/alu_output_queue.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/alu_output_queue_if.sv
// alu_output_queue_if
//   Groups the ALU-result push bus, the per-port acknowledge/pop bus, and the
//   per-port result outputs of alu_output_queue.
//   master : upstream/requester side (drives push + acks, observes outputs)
//   slave  : the queue itself
//   Signals:
//     prio_alu_out_vld     result valid this cycle
//     prio_alu_out_req_id  destination port of the result
//     alu_result           2*DATA_W result, payload in the low DATA_W bits
//     alu_overflow         overflow for the current result
//     local_error_found    invalid command/operand for the current result
//     out_ack              per-port pop
//     out_data             port i head data at [i*DATA_W +: DATA_W]
//     out_resp             port i head response at [2*i +: 2], 00 = empty
//     port_full            per-port FIFO full (registered)
//     drop_err             sticky: a result was discarded at a full port
interface alu_output_queue_if #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32,
    parameter int ID_W      = $clog2(NUM_PORTS)
);
    logic                          prio_alu_out_vld;
    logic [ID_W-1:0]               prio_alu_out_req_id;
    logic [2*DATA_W-1:0]           alu_result;
    logic                          alu_overflow;
    logic                          local_error_found;
    logic [NUM_PORTS-1:0]          out_ack;
    logic [NUM_PORTS*DATA_W-1:0]   out_data;
    logic [2*NUM_PORTS-1:0]        out_resp;
    logic [NUM_PORTS-1:0]          port_full;
    logic                          drop_err;

    modport master (
        output prio_alu_out_vld, prio_alu_out_req_id, alu_result,
               alu_overflow, local_error_found, out_ack,
        input  out_data, out_resp, port_full, drop_err
    );

    modport slave (
        input  prio_alu_out_vld, prio_alu_out_req_id, alu_result,
               alu_overflow, local_error_found, out_ack,
        output out_data, out_resp, port_full, drop_err
    );
endinterface

// File: rtl/alu_output_queue.sv
// alu_output_queue
//   Routes one ALU result per cycle into one of NUM_PORTS per-port FIFOs and
//   lets each requester port drain its FIFO with a valid/ack handshake.
//   Response code: 10 on local error or overflow, else 01; 00 means empty.
//   Ports:
//     c_clk  : clock, rising edge
//     reset  : asynchronous active-high reset, clears all queues
//     bus    : alu_output_queue_if.slave (push bus, acks, per-port outputs)
//   All outputs are functions of registered state only.

// One requester port: a DEPTH-entry FIFO with full-and-pop push acceptance.
module alu_output_queue_port #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic [1:0]        i_resp,
    input  logic              i_ack,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_resp,
    output logic              o_full,
    output logic              o_drop
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [1:0]        resp;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push_ok;
    ent_t             w_head;

    assign w_empty   = (r_cnt == '0);
    // Ack on an empty FIFO is simply ignored.
    assign w_pop     = i_ack && !w_empty;
    // A full FIFO still takes the push when its head leaves in the same cycle.
    assign w_push_ok = i_push && ((r_cnt != CNT_W'(DEPTH)) || w_pop);
    assign o_drop    = i_push && !w_push_ok;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_push_ok && !w_pop)
            w_cnt_nxt = r_cnt + CNT_W'(1);
        else if (!w_push_ok && w_pop)
            w_cnt_nxt = r_cnt - CNT_W'(1);
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_cnt  <= w_cnt_nxt;
            r_full <= (w_cnt_nxt == CNT_W'(DEPTH));
        end
    end

    // Storage needs no reset: it is only visible while the count is non-zero.
    always_ff @(posedge c_clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= '{resp: i_resp, data: i_data};
    end

    assign w_head = r_mem[r_rd_ptr];
    assign o_data = w_empty ? '0 : w_head.data;
    assign o_resp = w_empty ? 2'b00 : w_head.resp;
    assign o_full = r_full;
endmodule

module alu_output_queue #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int ID_W      = $clog2(NUM_PORTS)
) (
    input  logic               c_clk,
    input  logic               reset,
    alu_output_queue_if.slave  bus
);
    logic [NUM_PORTS-1:0] w_push;
    logic [NUM_PORTS-1:0] w_drop;
    logic [1:0]           w_resp;
    logic [DATA_W-1:0]    w_data;
    logic                 r_drop_err;
    logic                 w_unused_hi;

    assign w_resp = (bus.local_error_found || bus.alu_overflow) ? 2'b10 : 2'b01;
    assign w_data = bus.alu_result[DATA_W-1:0];
    // Upper half of the ALU result carries no payload for this stage.
    assign w_unused_hi = ^bus.alu_result[2*DATA_W-1:DATA_W];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign w_push[gi] = bus.prio_alu_out_vld &&
                                (bus.prio_alu_out_req_id == ID_W'(gi));

            alu_output_queue_port #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH)
            ) u_port (
                .c_clk  (c_clk),
                .reset  (reset),
                .i_push (w_push[gi]),
                .i_data (w_data),
                .i_resp (w_resp),
                .i_ack  (bus.out_ack[gi]),
                .o_data (bus.out_data[gi*DATA_W +: DATA_W]),
                .o_resp (bus.out_resp[2*gi +: 2]),
                .o_full (bus.port_full[gi]),
                .o_drop (w_drop[gi])
            );
        end
    endgenerate

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset)
            r_drop_err <= 1'b0;
        else if (|w_drop)
            r_drop_err <= 1'b1;
    end

    assign bus.drop_err = r_drop_err;
endmodule
